// File: rtl/muldiv_pkg.sv
// Shared types and constants for the iterative multiply/divide unit.
// Operation encoding matches the 2-bit op field driven by the decoder.
package muldiv_pkg;

    localparam int MD_ITERS = 32;
    localparam int CNT_W    = 5;

    typedef enum logic [1:0] {
        OP_MULT  = 2'b00,
        OP_MULTU = 2'b01,
        OP_DIV   = 2'b10,
        OP_DIVU  = 2'b11
    } op_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_FIX  = 2'd2
    } state_t;

    function automatic logic is_signed_op(input op_t o);
        return (o == OP_MULT) || (o == OP_DIV);
    endfunction

    function automatic logic is_div_op(input op_t o);
        return (o == OP_DIV) || (o == OP_DIVU);
    endfunction

    // Magnitude of a two's-complement word; 32'h80000000 maps to itself,
    // which is the correct unsigned magnitude.
    function automatic logic [31:0] abs_if(input logic [31:0] v, input logic en);
        return (en && v[31]) ? (~v + 32'd1) : v;
    endfunction

endpackage

// File: rtl/muldiv_ctrl.sv
// Sequencer for the multiply/divide unit: IDLE -> RUN (32 iterations) -> FIX.
// Produces the load/step/fix phase strobes, busy, and a registered done pulse.
module muldiv_ctrl
    import muldiv_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    output logic       busy,
    output logic       done,
    output logic       load,
    output logic       step,
    output logic       fix,
    output logic [1:0] state_dbg
);

    localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(MD_ITERS - 1);

    state_t            state_q;
    state_t            state_d;
    logic [CNT_W-1:0]  cnt_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            done    <= 1'b0;
        end else begin
            state_q <= state_d;
            done    <= fix;
            if (load) begin
                cnt_q <= '0;
            end else if (step) begin
                cnt_q <= cnt_q + CNT_W'(1);
            end
        end
    end

    // Handshake: start is taken only while busy=0; a start seen while busy
    // is dropped, never queued.
    always_comb begin
        state_d = state_q;
        load    = 1'b0;
        step    = 1'b0;
        fix     = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    load    = 1'b1;
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                step = 1'b1;
                if (cnt_q == LAST_ITER) begin
                    state_d = ST_FIX;
                end
            end
            ST_FIX: begin
                fix     = 1'b1;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign busy      = (state_q != ST_IDLE);
    assign state_dbg = state_q;

endmodule

// File: rtl/muldiv_unit.sv
// MIPS-style HI/LO multiply/divide unit: radix-2 shift-add multiply and
// restoring divide on magnitudes, with sign correction in a final FIX cycle.
module muldiv_unit
    import muldiv_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [1:0]  op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        hi_we,
    input  logic        lo_we,
    input  logic [31:0] wdata,
    output logic        busy,
    output logic        done,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    logic        load;
    logic        step;
    logic        fix;
    logic [1:0]  state_dbg;

    muldiv_ctrl u_ctrl (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .busy      (busy),
        .done      (done),
        .load      (load),
        .step      (step),
        .fix       (fix),
        .state_dbg (state_dbg)
    );

    // acc: multiply accumulator {partial product, multiplier}, or for divide
    // the dividend shifting out of [31] while quotient bits shift into [0].
    logic [63:0] acc;
    logic [31:0] rem;
    logic [31:0] opnd;
    logic        div_q;
    logic        neg_lo;
    logic        neg_hi;
    logic        div0;

    logic        sgn;
    logic        is_div;
    logic [31:0] mag_a;
    logic [31:0] mag_b;
    logic        mt_en;

    assign sgn    = is_signed_op(op_t'(op));
    assign is_div = is_div_op(op_t'(op));
    assign mag_a  = abs_if(a, sgn);
    assign mag_b  = abs_if(b, sgn);
    assign mt_en  = (state_dbg == ST_IDLE) && !start;

    logic [32:0] sum;
    logic [32:0] rem_sh;
    logic        sub_ok;
    logic [31:0] diff;
    logic [63:0] acc_nxt;
    logic [31:0] rem_nxt;

    always_comb begin
        sum     = {1'b0, acc[63:32]} + {1'b0, (acc[0] ? opnd : 32'd0)};
        rem_sh  = {rem, acc[31]};
        sub_ok  = (rem_sh >= {1'b0, opnd});
        diff    = rem_sh[31:0] - opnd;
        acc_nxt = acc;
        rem_nxt = rem;
        if (div_q) begin
            // When the trial subtract fails, rem_sh < divisor so it fits 32 bits.
            rem_nxt = sub_ok ? diff : rem_sh[31:0];
            acc_nxt = {acc[63:32], acc[30:0], sub_ok};
        end else begin
            acc_nxt = {sum, acc[31:1]};
        end
    end

    logic [63:0] prod_fix;
    logic [31:0] quo_fix;
    logic [31:0] rem_fix;
    logic [31:0] hi_res;
    logic [31:0] lo_res;

    always_comb begin
        prod_fix = neg_hi ? (~acc + 64'd1) : acc;
        quo_fix  = neg_lo ? (~acc[31:0] + 32'd1) : acc[31:0];
        rem_fix  = neg_hi ? (~rem + 32'd1) : rem;
        hi_res   = prod_fix[63:32];
        lo_res   = prod_fix[31:0];
        if (div_q) begin
            hi_res = rem_fix;
            lo_res = div0 ? 32'hFFFF_FFFF : quo_fix;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            acc    <= '0;
            rem    <= '0;
            opnd   <= '0;
            div_q  <= 1'b0;
            neg_lo <= 1'b0;
            neg_hi <= 1'b0;
            div0   <= 1'b0;
            hi     <= '0;
            lo     <= '0;
        end else begin
            if (load) begin
                acc    <= {32'd0, (is_div ? mag_a : mag_b)};
                opnd   <= is_div ? mag_b : mag_a;
                rem    <= '0;
                div_q  <= is_div;
                neg_lo <= sgn && (a[31] ^ b[31]);
                neg_hi <= sgn && (is_div ? a[31] : (a[31] ^ b[31]));
                div0   <= is_div && (b == 32'd0);
            end else if (step) begin
                acc <= acc_nxt;
                rem <= rem_nxt;
            end
            if (fix) begin
                hi <= hi_res;
                lo <= lo_res;
            end else if (mt_en) begin
                if (hi_we) hi <= wdata;
                if (lo_we) lo <= wdata;
            end
        end
    end

endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit: directed vector table, hand-built
// corner sequences, and random operations against an arithmetic model.
module tb_muldiv_unit;

    logic        clk;
    logic        reset;
    logic        start;
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic        hi_we;
    logic        lo_we;
    logic [31:0] wdata;
    logic        busy;
    logic        done;
    logic [31:0] hi;
    logic [31:0] lo;

    int n_checks = 0;
    int n_fail   = 0;

    muldiv_unit dut (
        .clk   (clk),
        .reset (reset),
        .start (start),
        .op    (op),
        .a     (a),
        .b     (b),
        .hi_we (hi_we),
        .lo_we (lo_we),
        .wdata (wdata),
        .busy  (busy),
        .done  (done),
        .hi    (hi),
        .lo    (lo)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] hi;
        logic [31:0] lo;
    } vec_t;

    vec_t vecs[9];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference: HI/LO straight from the arithmetic definitions.
    function automatic logic [63:0] model(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
        longint          sp;
        longint unsigned up;
        int              q;
        int              r;
        case (o)
            2'b00: begin
                sp = longint'($signed(x)) * longint'($signed(y));
                return 64'(sp);
            end
            2'b01: begin
                up = {32'd0, x} * {32'd0, y};
                return 64'(up);
            end
            2'b10: begin
                if (y == 32'd0) return {x, 32'hFFFF_FFFF};
                if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) return {32'd0, 32'h8000_0000};
                q = $signed(x) / $signed(y);
                r = $signed(x) % $signed(y);
                return {32'(r), 32'(q)};
            end
            default: begin
                if (y == 32'd0) return {x, 32'hFFFF_FFFF};
                return {x % y, x / y};
            end
        endcase
    endfunction

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 6))
            0: return 32'd0;
            1: return 32'd1;
            2: return 32'hFFFF_FFFF;
            3: return 32'h8000_0000;
            4: return 32'h7FFF_FFFF;
            5: return 32'($urandom_range(0, 40)) - 32'd20;
            default: return $urandom;
        endcase
    endfunction

    // inj: 0 none, 1 second start at RUN cycle 5, 2 hi_we at RUN cycle 3,
    // 3 lo_we coincident with the launching start.
    task automatic run_op(input logic [1:0] op_i, input logic [31:0] a_i, input logic [31:0] b_i,
                          input int inj, output int lat, output int n_done);
        logic [63:0] pre;
        pre    = {hi, lo};
        lat    = -1;
        n_done = 0;
        @(negedge clk);
        start = 1'b1; op = op_i; a = a_i; b = b_i;
        if (inj == 3) begin
            lo_we = 1'b1; wdata = 32'h5A5A_5A5A;
        end
        @(posedge clk); #1;
        start = 1'b0; lo_we = 1'b0;
        a = $urandom; b = $urandom; op = 2'($urandom_range(0, 3));
        check("busy_after_start", {63'd0, busy}, 64'd1);
        check("hilo_after_start", {hi, lo}, pre);
        for (int n = 1; n <= 40; n++) begin
            @(negedge clk);
            if (inj == 1 && n == 5) begin
                start = 1'b1; op = 2'($urandom_range(0, 3)); a = $urandom; b = $urandom;
            end
            if (inj == 2 && n == 3) begin
                hi_we = 1'b1; wdata = 32'hDEAD_BEEF;
            end
            @(posedge clk); #1;
            start = 1'b0; hi_we = 1'b0;
            if (n == 16) check("hilo_hold_run", {hi, lo}, pre);
            if (n == 32) check("busy_last_run", {63'd0, busy}, 64'd1);
            if (n == 33) check("busy_after_fix", {63'd0, busy}, 64'd0);
            if (done) begin
                n_done++;
                if (lat < 0) lat = n;
            end
        end
    endtask

    task automatic do_op(input logic [1:0] op_i, input logic [31:0] a_i, input logic [31:0] b_i, input int inj);
        int          lat;
        int          nd;
        logic [63:0] exp;
        exp = model(op_i, a_i, b_i);
        run_op(op_i, a_i, b_i, inj, lat, nd);
        check($sformatf("latency op%0d", op_i), 64'(lat), 64'd33);
        check($sformatf("done_count op%0d", op_i), 64'(nd), 64'd1);
        check($sformatf("result op%0d a=%h b=%h", op_i, a_i, b_i), {hi, lo}, exp);
    endtask

    task automatic mt_write(input logic wh, input logic wl, input logic [31:0] d);
        logic [31:0] exp_hi;
        logic [31:0] exp_lo;
        exp_hi = wh ? d : hi;
        exp_lo = wl ? d : lo;
        @(negedge clk);
        hi_we = wh; lo_we = wl; wdata = d;
        @(posedge clk); #1;
        hi_we = 1'b0; lo_we = 1'b0;
        check("mt_write", {hi, lo}, {exp_hi, exp_lo});
    endtask

    initial begin
        int lat;
        int nd;

        vecs[0] = '{2'b00, 32'hFFFF_FFFE, 32'h0000_0003, 32'hFFFF_FFFF, 32'hFFFF_FFFA};
        vecs[1] = '{2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001};
        vecs[2] = '{2'b10, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 32'hFFFF_FFFD};
        vecs[3] = '{2'b11, 32'h0000_0007, 32'h0000_0000, 32'h0000_0007, 32'hFFFF_FFFF};
        vecs[4] = '{2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000};
        vecs[5] = '{2'b11, 32'd100,       32'd7,         32'd2,         32'd14};
        vecs[6] = '{2'b10, 32'd7,         32'hFFFF_FFFE, 32'd1,         32'hFFFF_FFFD};
        vecs[7] = '{2'b00, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000};
        vecs[8] = '{2'b10, 32'hFFFF_FFF9, 32'h0000_0000, 32'hFFFF_FFF9, 32'hFFFF_FFFF};

        reset = 1'b1; start = 1'b0; op = 2'b00; a = '0; b = '0;
        hi_we = 1'b0; lo_we = 1'b0; wdata = '0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_state", {30'd0, busy, done, hi, lo}, 64'd0);
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk); #1;
        check("post_reset_state", {30'd0, busy, done, hi, lo}, 64'd0);

        foreach (vecs[i]) begin
            run_op(vecs[i].op, vecs[i].a, vecs[i].b, 0, lat, nd);
            check($sformatf("vec%0d latency", i), 64'(lat), 64'd33);
            check($sformatf("vec%0d done_count", i), 64'(nd), 64'd1);
            check($sformatf("vec%0d hi_lo", i), {hi, lo}, {vecs[i].hi, vecs[i].lo});
        end

        // Ignored second start, MT write while busy, start beating lo_we.
        do_op(2'b00, 32'h0001_2345, 32'hFFFF_0003, 1);
        do_op(2'b11, 32'hDEAD_0000, 32'd13, 2);
        do_op(2'b01, 32'd2, 32'd3, 3);

        mt_write(1'b0, 1'b1, 32'h1234_5678);
        mt_write(1'b1, 1'b0, 32'hCAFE_F00D);
        mt_write(1'b1, 1'b1, 32'h0BAD_0BAD);

        // Asynchronous reset in the middle of RUN aborts without done.
        @(negedge clk);
        start = 1'b1; op = 2'b01; a = 32'd5; b = 32'd7;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (10) @(posedge clk);
        #2 reset = 1'b1;
        #1;
        check("midrun_reset_state", {30'd0, busy, done, hi, lo}, 64'd0);
        @(negedge clk);
        reset = 1'b0;
        nd = 0;
        for (int n = 0; n < 40; n++) begin
            @(posedge clk); #1;
            if (done || busy) nd++;
        end
        check("no_activity_after_abort", 64'(nd), 64'd0);
        vecs[0] = '{2'b01, 32'd3, 32'd4, 32'd0, 32'd12};
        run_op(vecs[0].op, vecs[0].a, vecs[0].b, 0, lat, nd);
        check("restart latency", 64'(lat), 64'd33);
        check("restart hi_lo", {hi, lo}, {vecs[0].hi, vecs[0].lo});

        for (int k = 0; k < 40; k++) begin
            do_op(2'($urandom_range(0, 3)), pick(), pick(), 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/muldiv_unit.md
MULDIV_UNIT -- requirements
Module: muldiv_unit

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-high reset, as listed below.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 start  input  1  launch request, sampled on rising clk.
REQ-005 op  input  2  operation: 00 MULT, 01 MULTU, 10 DIV, 11 DIVU.
REQ-006 a  input  32  rs operand: multiplicand or dividend.
REQ-007 b  input  32  rt operand: multiplier or divisor.
REQ-008 hi_we  input  1  MTHI write strobe.
REQ-009 lo_we  input  1  MTLO write strobe.
REQ-010 wdata  input  32  MTHI/MTLO data.
REQ-011 busy  output  1  operation in progress.
REQ-012 done  output  1  one-cycle pulse when HI/LO are updated by an operation.
REQ-013 hi  output  32  HI register: product upper word or remainder.
REQ-014 lo  output  32  LO register: product lower word or quotient.

Function
REQ-015 FSM states SHALL be IDLE, RUN and FIX; reset state is IDLE.
REQ-016 IDLE, start=1: latch op; latch |a| and |b| for signed ops, raw a and b for unsigned; latch the result-sign flags; clear the iteration counter; go to RUN; busy=1 from the next cycle.
REQ-017 RUN SHALL perform one radix-2 iteration per cycle.
- Multiply: shift-add into a 64-bit accumulator.
- Divide: restoring shift-subtract with a 33-bit partial remainder.
REQ-018 RUN SHALL last exactly 32 cycles (counter 0..31), then go to FIX.
REQ-019 FIX SHALL apply sign correction, write HI and LO, assert done for exactly one cycle, and return to IDLE with busy=0.
REQ-020 Latency SHALL be fixed: start sampled at edge 0 gives HI/LO updated and done=1 after edge 33, for all ops and operands.
REQ-021 Signed MULT SHALL negate the 64-bit product when a[31]^b[31]=1.
REQ-022 Signed DIV SHALL apply these sign rules.
- Quotient is negated when a[31]^b[31]=1.
- Remainder takes the sign of the dividend.
- Quotient truncates toward zero.
REQ-023 Divide by zero (b=0) SHALL give lo=32'hFFFFFFFF and hi=a, for DIV and DIVU, with full latency.
REQ-024 DIV 32'h80000000 / 32'hFFFFFFFF SHALL give lo=32'h80000000 and hi=0.
REQ-025 start while busy=1 SHALL be ignored, with no queuing.
REQ-026 hi_we/lo_we SHALL write wdata to HI/LO on the next edge only when state=IDLE and start=0; they are ignored otherwise.
REQ-027 When start, hi_we and lo_we coincide in IDLE, start SHALL win.
REQ-028 hi and lo SHALL hold their values during RUN and change only in FIX, on reset, or on an IDLE MTHI/MTLO write.
REQ-029 a, b and op SHALL be don't-care after the start edge.

Reset
REQ-030 reset SHALL force, asynchronously:
- state=IDLE, busy=0, done=0;
- hi=0, lo=0;
- counter and accumulators cleared.
REQ-031 reset during RUN or FIX SHALL abort the operation with no done pulse; the first start after reset release is accepted normally.

Structure
REQ-032 A shared package muldiv_pkg SHALL hold:
- the op encoding enum (OP_MULT, OP_MULTU, OP_DIV, OP_DIVU);
- the FSM state enum;
- constant MD_ITERS=32.
REQ-033 FSM, counter and datapath SHALL reside in muldiv_unit.
REQ-034 One sub-module, muldiv_ctrl (FSM plus 5-bit iteration counter, producing busy, done and phase strobes), SHALL be used.

Verification
REQ-035 MULT a=32'hFFFFFFFE, b=32'h00000003 -> hi=32'hFFFFFFFF, lo=32'hFFFFFFFA, done exactly 33 cycles after the start edge.
REQ-036 MULTU a=b=32'hFFFFFFFF -> hi=32'hFFFFFFFE, lo=32'h00000001.
REQ-037 DIV a=32'hFFFFFFF9 (-7), b=2 -> lo=32'hFFFFFFFD, hi=32'hFFFFFFFF; DIVU a=7, b=0 -> lo=32'hFFFFFFFF, hi=7.
REQ-038 DIV a=32'h80000000, b=32'hFFFFFFFF -> lo=32'h80000000, hi=0, no other side effect.
REQ-039 Second start with new operands at RUN cycle 5 -> ignored, first result unchanged, single done pulse; lo_we=1 with wdata=32'h12345678 in IDLE -> lo=32'h12345678 next cycle.
REQ-040 reset asserted at RUN cycle 10 -> busy=0, hi=lo=0 immediately, no done; new MULTU 3*4 then completes with lo=12, hi=0.
